// File: rtl/multi_clk_gen.sv
// Multi-channel registered clock/pulse generator; each channel is free-running or a counted burst.
// Latency: enable/start/sync sampled at edge k show on clk_o/busy after edge k+1; done aligns with busy falling.
// Backpressure: none; start is ignored while a channel runs, and enable/burst ends always finish the current period.
module multi_clk_gen #(
    parameter int CHANNELS     = 4,
    parameter int COUNTER_BITS = 16,
    parameter int PULSE_BITS   = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNELS-1:0]              enable,
    input  logic [CHANNELS-1:0]              mode,
    input  logic [CHANNELS-1:0]              start,
    input  logic                             sync,
    input  logic [CHANNELS*COUNTER_BITS-1:0] divider,
    input  logic [CHANNELS*COUNTER_BITS-1:0] high_time,
    input  logic [CHANNELS*PULSE_BITS-1:0]   pulse,
    output logic [CHANNELS-1:0]              clk_o,
    output logic [CHANNELS-1:0]              busy,
    output logic [CHANNELS-1:0]              done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [COUNTER_BITS-1:0] CNT_ONE = COUNTER_BITS'(1);
    localparam logic [COUNTER_BITS-1:0] CNT_TWO = COUNTER_BITS'(2);
    localparam logic [PULSE_BITS-1:0]   REM_ONE = PULSE_BITS'(1);

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            logic [COUNTER_BITS-1:0] div_in;
            logic [COUNTER_BITS-1:0] hi_in;
            logic [PULSE_BITS-1:0]   pulse_in;
            logic [COUNTER_BITS-1:0] d_clamp;
            logic [COUNTER_BITS-1:0] h_clamp;

            logic [0:0]              state_q;
            logic [COUNTER_BITS-1:0] cnt_q;
            logic [COUNTER_BITS-1:0] d_q;
            logic [COUNTER_BITS-1:0] h_q;
            logic                    mode_q;
            logic [PULSE_BITS-1:0]   rem_q;
            logic                    fin_q;

            logic                    clk_q;
            logic                    busy_q;
            logic                    done_q;

            logic                    go;
            logic                    wrap;
            logic                    stop;

            assign div_in   = divider[g*COUNTER_BITS +: COUNTER_BITS];
            assign hi_in    = high_time[g*COUNTER_BITS +: COUNTER_BITS];
            assign pulse_in = pulse[g*PULSE_BITS +: PULSE_BITS];

            // Clamp so the output always toggles: period >= 2, high time within 1..D-1.
            assign d_clamp = (div_in < CNT_TWO) ? CNT_TWO : div_in;
            assign h_clamp = (hi_in == '0)      ? CNT_ONE :
                             (hi_in >= d_clamp) ? (d_clamp - CNT_ONE) : hi_in;

            // A zero-length burst request is dropped here so it never reaches RUN or done.
            assign go   = mode[g] ? (start[g] && (pulse_in != '0)) : enable[g];
            assign wrap = (cnt_q == (d_q - CNT_ONE));
            assign stop = mode_q ? (rem_q == REM_ONE) : ~enable[g];

            // Channel sequencer: period counter, config latch at start/wrap, burst countdown, sync restart.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    d_q     <= '0;
                    h_q     <= '0;
                    mode_q  <= 1'b0;
                    rem_q   <= '0;
                    fin_q   <= 1'b0;
                end else begin
                    fin_q <= 1'b0;
                    case (state_q)
                        ST_IDLE: begin
                            cnt_q <= '0;
                            if (go) begin
                                state_q <= ST_RUN;
                                d_q     <= d_clamp;
                                h_q     <= h_clamp;
                                mode_q  <= mode[g];
                                rem_q   <= mode[g] ? pulse_in : '0;
                            end
                        end
                        default: begin
                            // The wrap wins over sync; sync alone restarts without touching rem.
                            if (wrap) begin
                                cnt_q <= '0;
                                if (stop) begin
                                    state_q <= ST_IDLE;
                                    fin_q   <= mode_q;
                                end else begin
                                    d_q <= d_clamp;
                                    h_q <= h_clamp;
                                    if (mode_q) begin
                                        rem_q <= rem_q - REM_ONE;
                                    end
                                end
                            end else if (sync) begin
                                cnt_q <= '0;
                            end else begin
                                cnt_q <= cnt_q + CNT_ONE;
                            end
                        end
                    endcase
                end
            end

            // Output flops: one stage behind the counter, so every output is a clean register.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    clk_q  <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end else begin
                    clk_q  <= (state_q == ST_RUN) && (cnt_q < h_q);
                    busy_q <= (state_q == ST_RUN);
                    done_q <= fin_q;
                end
            end

            assign clk_o[g] = clk_q;
            assign busy[g]  = busy_q;
            assign done[g]  = done_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_clk_gen.sv
// Bench for multi_clk_gen: timestamp-based period model checked every cycle, plus literal waveform checks.
// Latency: model output after edge e reflects decisions taken up to edge e-1.
// Backpressure: none; stimulus is fixed-length directed sequences.
module tb_multi_clk_gen;
    localparam int CH = 4;
    localparam int CB = 16;
    localparam int PB = 16;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             sync      = 1'b0;
    logic [CH-1:0]    enable    = '0;
    logic [CH-1:0]    mode      = '0;
    logic [CH-1:0]    start     = '0;
    logic [CH*CB-1:0] divider   = '0;
    logic [CH*CB-1:0] high_time = '0;
    logic [CH*PB-1:0] pulse     = '0;
    logic [CH-1:0]    clk_o;
    logic [CH-1:0]    busy;
    logic [CH-1:0]    done;

    int n_vec = 0;
    int n_err = 0;

    multi_clk_gen #(.CHANNELS(CH), .COUNTER_BITS(CB), .PULSE_BITS(PB)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .start     (start),
        .sync      (sync),
        .divider   (divider),
        .high_time (high_time),
        .pulse     (pulse),
        .clk_o     (clk_o),
        .busy      (busy),
        .done      (done)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ch(input int c, input int d, input int h, input int p, input logic m);
        divider[c*CB +: CB]   = CB'(d);
        high_time[c*CB +: CB] = CB'(h);
        pulse[c*PB +: PB]     = PB'(p);
        mode[c]               = m;
    endtask

    // ---------------- reference model ----------------
    // Each running channel is described by the edge index t0 at which its current period
    // becomes visible; the shown phase is simply (edge - t0).
    int          m_act[CH];
    int          m_t0[CH];
    int          m_d[CH];
    int          m_h[CH];
    int          m_burst[CH];
    int          m_rem[CH];
    int          m_fin[CH];
    int          ecount = 0;
    logic [CH-1:0] e_clk  = '0;
    logic [CH-1:0] e_busy = '0;
    logic [CH-1:0] e_done = '0;

    function automatic int clamp_d(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int clamp_h(input int h, input int d);
        if (h < 1) return 1;
        if (h > d - 1) return d - 1;
        return h;
    endfunction

    initial begin
        for (int c = 0; c < CH; c++) begin
            m_act[c] = 0; m_t0[c] = 0; m_d[c] = 2; m_h[c] = 1;
            m_burst[c] = 0; m_rem[c] = 0; m_fin[c] = 0;
        end
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int c = 0; c < CH; c++) begin
                    m_act[c] = 0;
                    m_fin[c] = 0;
                end
                e_clk  = '0;
                e_busy = '0;
                e_done = '0;
            end else begin
                ecount++;
                for (int c = 0; c < CH; c++) begin
                    int dv, hv, pv;
                    dv = int'(divider[c*CB +: CB]);
                    hv = int'(high_time[c*CB +: CB]);
                    pv = int'(pulse[c*PB +: PB]);
                    e_done[c] = (m_fin[c] != 0);
                    e_busy[c] = (m_act[c] != 0);
                    e_clk[c]  = (m_act[c] != 0) && ((ecount - m_t0[c]) < m_h[c]);
                    m_fin[c]  = 0;
                    if (m_act[c] == 0) begin
                        if (mode[c] ? (start[c] && pv != 0) : enable[c]) begin
                            m_act[c]   = 1;
                            m_t0[c]    = ecount + 1;
                            m_d[c]     = clamp_d(dv);
                            m_h[c]     = clamp_h(hv, m_d[c]);
                            m_burst[c] = mode[c] ? 1 : 0;
                            m_rem[c]   = pv;
                        end
                    end else if (ecount == m_t0[c] + m_d[c] - 1) begin
                        if ((m_burst[c] != 0) ? (m_rem[c] == 1) : !enable[c]) begin
                            m_act[c] = 0;
                            m_fin[c] = m_burst[c];
                        end else begin
                            m_t0[c] = ecount + 1;
                            m_d[c]  = clamp_d(dv);
                            m_h[c]  = clamp_h(hv, m_d[c]);
                            if (m_burst[c] != 0) m_rem[c] = m_rem[c] - 1;
                        end
                    end else if (sync) begin
                        m_t0[c] = ecount + 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        n_vec++;
        if (clk_o !== e_clk || busy !== e_busy || done !== e_done) begin
            n_err++;
            $display("FAIL model_cmp @%0t: clk_o %b want %b, busy %b want %b, done %b want %b",
                     $time, clk_o, e_clk, busy, e_busy, done, e_done);
        end
    end

    // ---------------- directed stimulus ----------------
    logic [9:0]  fr;
    logic [5:0]  fb, fc;
    logic [11:0] c2, c3;
    logic [7:0]  s0, s2;
    logic        b_s[1:30];
    logic        c_s[1:30];
    logic        d_s[1:30];
    int          nb, nh, nd, d_idx;
    logic        restarted;
    logic        seen;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("reset_clk_o", 32'(clk_o), 32'd0);
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_done",  32'(done),  32'd0);

        // Free-run ch0: D=5, H=2
        @(negedge clk);
        set_ch(0, 5, 2, 0, 1'b0);
        enable[0] = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            fr[9-i] = clk_o[0];
        end
        chk("freerun_pattern", 32'(fr), 32'b1100011000);
        @(posedge clk); #1;
        @(negedge clk);
        enable[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            fb[5-i] = busy[0];
            fc[5-i] = clk_o[0];
        end
        chk("freerun_stop_busy", 32'(fb), 32'b111100);
        chk("freerun_stop_clk",  32'(fc), 32'b100000);

        // Burst ch1: D=4, H=1, 3 periods; start while busy, restart in the done cycle
        @(negedge clk);
        set_ch(1, 4, 1, 3, 1'b1);
        start[1] = 1'b1;
        @(posedge clk); #1;
        start[1]  = 1'b0;
        restarted = 1'b0;
        d_idx     = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            start[1] = 1'b0;
            b_s[i] = busy[1];
            c_s[i] = clk_o[1];
            d_s[i] = done[1];
            if (i == 5) start[1] = 1'b1;
            if (done[1] && !restarted) begin
                start[1]  = 1'b1;
                restarted = 1'b1;
                d_idx     = i;
            end
        end
        start[1] = 1'b0;
        nb = 0; nh = 0; nd = 0;
        for (int i = 1; i <= 13; i++) begin
            nb += int'(b_s[i]);
            nh += int'(c_s[i]);
        end
        for (int i = 1; i <= 30; i++) nd += int'(d_s[i]);
        chk("burst_busy_cycles", 32'(nb), 32'd12);
        chk("burst_high_pulses", 32'(nh), 32'd3);
        chk("burst_done_index",  32'(d_idx), 32'd13);
        chk("burst_busy_at_done", 32'(b_s[13]), 32'd0);
        chk("restart_gap_busy",  32'(b_s[14]), 32'd0);
        chk("restart_busy",      32'(b_s[15]), 32'd1);
        chk("burst_done_total",  32'(nd), 32'd2);

        // Clamping: ch2 D=0,H=0 -> clk/2; ch3 D=6,H=9 -> 5 high, 1 low
        @(negedge clk);
        set_ch(2, 0, 0, 0, 1'b0);
        set_ch(3, 6, 9, 0, 1'b0);
        enable[3:2] = 2'b11;
        @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            c2[11-i] = clk_o[2];
            c3[11-i] = clk_o[3];
        end
        chk("clamp_div0", 32'(c2), 32'b101010101010);
        chk("clamp_hi9",  32'(c3), 32'b111110111110);
        @(negedge clk);
        enable[3:2] = 2'b00;
        repeat (10) @(negedge clk);

        // Sync: ch0 D=4, ch2 D=8 out of phase; ch1 burst of 2 interrupted by sync
        set_ch(0, 4, 2, 0, 1'b0);
        set_ch(2, 8, 4, 0, 1'b0);
        set_ch(1, 4, 1, 2, 1'b1);
        enable[0] = 1'b1;
        start[1]  = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        nb = 0; d_idx = 0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            sync = 1'b0;
            if (i >= 8 && i <= 15) begin
                s0[15-i] = clk_o[0];
                s2[15-i] = clk_o[2];
            end
            nb += int'(busy[1]);
            if (done[1] && d_idx == 0) d_idx = i;
            if (i == 2) enable[2] = 1'b1;
            if (i == 6) sync = 1'b1;
        end
        chk("sync_ch0_pattern", 32'(s0), 32'b11001100);
        chk("sync_ch2_pattern", 32'(s2), 32'b11110000);
        chk("sync_burst_busy",  32'(nb), 32'd11);
        chk("sync_burst_done",  32'(d_idx), 32'd12);
        @(negedge clk);
        enable[0] = 1'b0;
        enable[2] = 1'b0;
        repeat (12) @(negedge clk);

        // start with pulse=0 is ignored
        set_ch(3, 4, 1, 0, 1'b1);
        start[3] = 1'b1;
        @(negedge clk);
        start[3] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | busy[3] | done[3];
        end
        chk("pulse0_ignored", 32'(seen), 32'd0);

        // start and sync together on an idle channel
        @(negedge clk);
        set_ch(3, 4, 1, 2, 1'b1);
        start[3] = 1'b1;
        sync     = 1'b1;
        @(posedge clk); #1;
        start[3] = 1'b0;
        sync     = 1'b0;
        @(posedge clk); #1;
        chk("start_sync_busy", 32'(busy[3]), 32'd1);
        chk("start_sync_clk",  32'(clk_o[3]), 32'd1);
        repeat (10) @(negedge clk);

        // Mid-period reconfiguration takes effect at the next period (model-checked)
        set_ch(0, 5, 2, 0, 1'b0);
        enable[0] = 1'b1;
        repeat (2) @(negedge clk);
        set_ch(0, 3, 1, 0, 1'b0);
        repeat (9) @(negedge clk);
        enable[0] = 1'b0;
        repeat (6) @(negedge clk);

        // Asynchronous reset mid-run
        set_ch(0, 4, 2, 0, 1'b0);
        set_ch(1, 4, 1, 3, 1'b1);
        enable[0] = 1'b1;
        start[1]  = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_busy", 32'(busy[1:0]), 32'd3);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_clk_o", 32'(clk_o), 32'd0);
        chk("async_reset_busy",  32'(busy),  32'd0);
        enable[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_reset_idle", 32'({clk_o, busy, done}), 32'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
